// File: rtl/branch_predictor_gshare_pkg.sv
// Shared types for the branch prediction unit.
//   word_t  : 32-bit architectural word (PCs, targets)
//   ctr2_t  : 2-bit direction counter, with named states from
//             strongly-not-taken to strongly-taken
//   seq_pc  : fall-through address of a 4-byte instruction
package branch_predictor_gshare_pkg;

    typedef logic [31:0] word_t;
    typedef logic [1:0]  ctr2_t;

    localparam ctr2_t CTR_SNT = 2'b00;
    localparam ctr2_t CTR_WNT = 2'b01;
    localparam ctr2_t CTR_WT  = 2'b10;
    localparam ctr2_t CTR_ST  = 2'b11;

    function automatic word_t seq_pc(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_gshare_sat_counter.sv
// Generic saturating up/down counter, next-state only (the caller owns the
// register). Used for the PHT 2-bit cells and for the performance counters.
//   count      in  W  current value
//   en         in  1  step enable
//   up         in  1  1 = increment, 0 = decrement
//   count_next out W  value after the step, clamped at 0 and all-ones
module sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] count,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] count_next
);

    // Step toward the selected rail, holding once it is reached
    always_comb begin
        count_next = count;
        if (en && up && (count != {W{1'b1}})) begin
            count_next = count + W'(1);
        end else if (en && !up && (count != {W{1'b0}})) begin
            count_next = count - W'(1);
        end else begin
            count_next = count;
        end
    end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Branch prediction unit: tagged BTB plus a PHT of 2-bit counters, indexed
// bimodally (MODE 0) or gshare-style (MODE 1). Lookup and resolve are
// combinational; training, history and perf counters update on CLK.
//   CLK, nRST                 clock, async active-low reset
//   fetch_pc                  PC being fetched
//   fetch_predict/target/ghr  prediction, next fetch address, history snapshot
//   mem_branch/taken/pc       resolved conditional branch in MEM
//   mem_target_res            resolved taken target
//   mem_target/predict/ghr    values carried from fetch with the branch
//   mem_flush, mem_branch_miss  redirect request, direction mispredict
//   perf_branches/misses      saturating resolve and flush counts
module branch_predictor_gshare
    import branch_predictor_gshare_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int GHR_BITS = 4,
    parameter int MODE     = 0,
    parameter int PERF_W   = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [31:0]         fetch_pc,
    output logic                fetch_predict,
    output logic [31:0]         fetch_target,
    output logic [GHR_BITS-1:0] fetch_ghr,
    input  logic                mem_branch,
    input  logic                mem_taken,
    input  logic [31:0]         mem_pc,
    input  logic [31:0]         mem_target_res,
    input  logic [31:0]         mem_target,
    input  logic                mem_predict,
    input  logic [GHR_BITS-1:0] mem_ghr,
    output logic                mem_flush,
    output logic                mem_branch_miss,
    output logic [PERF_W-1:0]   perf_branches,
    output logic [PERF_W-1:0]   perf_misses
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        word_t            target;
    } btb_entry_t;

    btb_entry_t          btb_r [ENTRIES];
    ctr2_t               pht_r [ENTRIES];
    logic [GHR_BITS-1:0] ghr_r;
    logic [PERF_W-1:0]   perf_branches_r;
    logic [PERF_W-1:0]   perf_misses_r;

    logic [IDX-1:0]      f_bidx_s, f_pidx_s, u_bidx_s, u_pidx_s;
    logic [TAG_W-1:0]    f_tag_s, u_tag_s;
    logic [IDX-1:0]      f_hist_s, u_hist_s;
    logic                f_hit_s, f_predict_s, miss_s, flush_s;
    word_t               f_pred_target_s;
    ctr2_t               pht_next_s;
    logic [GHR_BITS-1:0] ghr_next_s;
    logic [PERF_W-1:0]   pb_next_s, pm_next_s;
    logic                unused_s;

    // The byte-offset bits never take part in indexing or tagging
    assign unused_s = ^{fetch_pc[1:0], mem_pc[1:0]};

    // Field extraction; history is zero-extended to the index width
    assign f_bidx_s = fetch_pc[IDX+1:2];
    assign f_tag_s  = fetch_pc[31:IDX+2];
    assign u_bidx_s = mem_pc[IDX+1:2];
    assign u_tag_s  = mem_pc[31:IDX+2];
    assign f_hist_s = IDX'(ghr_r);
    assign u_hist_s = IDX'(mem_ghr);
    assign f_pidx_s = (MODE == 1) ? (f_bidx_s ^ f_hist_s) : f_bidx_s;
    assign u_pidx_s = (MODE == 1) ? (u_bidx_s ^ u_hist_s) : u_bidx_s;

    // Fetch-side lookup against the current (pre-update) tables
    always_comb begin
        f_hit_s     = btb_r[f_bidx_s].valid && (btb_r[f_bidx_s].tag == f_tag_s);
        f_predict_s = f_hit_s && pht_r[f_pidx_s][1];
        if (f_predict_s) begin
            f_pred_target_s = btb_r[f_bidx_s].target;
        end else begin
            f_pred_target_s = seq_pc(fetch_pc);
        end
    end

    // MEM-side resolve: wrong direction, or taken to an unexpected target
    always_comb begin
        miss_s  = 1'b0;
        flush_s = 1'b0;
        if (mem_branch) begin
            miss_s  = (mem_predict != mem_taken);
            flush_s = miss_s || (mem_taken && mem_predict && (mem_target != mem_target_res));
        end else begin
            miss_s  = 1'b0;
            flush_s = 1'b0;
        end
    end

    // Next fetch address: a redirect from MEM overrides the prediction
    always_comb begin
        if (flush_s) begin
            fetch_target = mem_taken ? mem_target_res : seq_pc(mem_pc);
        end else begin
            fetch_target = f_pred_target_s;
        end
    end

    // Casting the widened shift keeps the low GHR_BITS, which also covers GHR_BITS = 1
    assign ghr_next_s = GHR_BITS'({ghr_r, mem_taken});

    sat_counter #(.W(2)) u_pht_ctr (
        .count      (pht_r[u_pidx_s]),
        .en         (1'b1),
        .up         (mem_taken),
        .count_next (pht_next_s)
    );

    sat_counter #(.W(PERF_W)) u_perf_branches (
        .count      (perf_branches_r),
        .en         (mem_branch),
        .up         (1'b1),
        .count_next (pb_next_s)
    );

    sat_counter #(.W(PERF_W)) u_perf_misses (
        .count      (perf_misses_r),
        .en         (flush_s),
        .up         (1'b1),
        .count_next (pm_next_s)
    );

    // Training: PHT step, BTB fill on taken, history shift, perf counting
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_r[i] <= '0;
                pht_r[i] <= CTR_WNT;
            end
            ghr_r           <= {GHR_BITS{1'b0}};
            perf_branches_r <= {PERF_W{1'b0}};
            perf_misses_r   <= {PERF_W{1'b0}};
        end else if (mem_branch) begin
            pht_r[u_pidx_s] <= pht_next_s;
            if (mem_taken) begin
                btb_r[u_bidx_s] <= '{valid: 1'b1, tag: u_tag_s, target: mem_target_res};
            end
            ghr_r           <= ghr_next_s;
            perf_branches_r <= pb_next_s;
            perf_misses_r   <= pm_next_s;
        end
    end

    assign fetch_predict   = f_predict_s;
    assign fetch_ghr       = ghr_r;
    assign mem_flush       = flush_s;
    assign mem_branch_miss = miss_s;
    assign perf_branches   = perf_branches_r;
    assign perf_misses     = perf_misses_r;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Bench for branch_predictor_gshare: a bimodal instance (PERF_W = 4) and a
// gshare instance (PERF_W = 32) share the stimulus; each is compared against
// a table-level reference model of the prediction rules.
module tb_branch_predictor_gshare;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] fetch_pc = 32'h0;
    logic        mem_branch = 1'b0;
    logic        mem_taken = 1'b0;
    logic [31:0] mem_pc = 32'h0;
    logic [31:0] mem_target_res = 32'h0;
    logic        mpred [2];
    logic [31:0] mtgt [2];
    logic [3:0]  mghr [2];

    logic        f_pred_w [2];
    logic [31:0] f_tgt_w [2];
    logic [3:0]  f_ghr_w [2];
    logic        flush_w [2];
    logic        miss_w [2];
    logic [3:0]  pb0, pm0;
    logic [31:0] pb1, pm1;

    int vectors = 0;
    int miscompares = 0;

    // reference model state, per instance (0 = bimodal, 1 = gshare)
    bit          m_valid [2][16];
    longint      m_tag [2][16];
    logic [31:0] m_tgt [2][16];
    int          m_pht [2][16];
    int          m_ghr [2];
    longint      m_pb [2];
    longint      m_pm [2];
    longint      pmax [2];

    always #5 CLK = ~CLK;

    branch_predictor_gshare #(.ENTRIES(16), .GHR_BITS(4), .MODE(0), .PERF_W(4)) dut0 (
        .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc),
        .fetch_predict(f_pred_w[0]), .fetch_target(f_tgt_w[0]), .fetch_ghr(f_ghr_w[0]),
        .mem_branch(mem_branch), .mem_taken(mem_taken), .mem_pc(mem_pc),
        .mem_target_res(mem_target_res), .mem_target(mtgt[0]), .mem_predict(mpred[0]),
        .mem_ghr(mghr[0]), .mem_flush(flush_w[0]), .mem_branch_miss(miss_w[0]),
        .perf_branches(pb0), .perf_misses(pm0)
    );

    branch_predictor_gshare #(.ENTRIES(16), .GHR_BITS(4), .MODE(1), .PERF_W(32)) dut1 (
        .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc),
        .fetch_predict(f_pred_w[1]), .fetch_target(f_tgt_w[1]), .fetch_ghr(f_ghr_w[1]),
        .mem_branch(mem_branch), .mem_taken(mem_taken), .mem_pc(mem_pc),
        .mem_target_res(mem_target_res), .mem_target(mtgt[1]), .mem_predict(mpred[1]),
        .mem_ghr(mghr[1]), .mem_flush(flush_w[1]), .mem_branch_miss(miss_w[1]),
        .perf_branches(pb1), .perf_misses(pm1)
    );

    task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    function automatic int bidx_of(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd16);
    endfunction

    function automatic longint tag_of(input logic [31:0] pc);
        return longint'(pc / 32'd64);
    endfunction

    function automatic int pidx_of(input int d, input logic [31:0] pc, input int hist);
        return (d == 1) ? (bidx_of(pc) ^ (hist % 16)) : bidx_of(pc);
    endfunction

    function automatic bit model_predict(input int d, input logic [31:0] pc);
        int b;
        b = bidx_of(pc);
        return m_valid[d][b] && (m_tag[d][b] == tag_of(pc)) && (m_pht[d][pidx_of(d, pc, m_ghr[d])] >= 2);
    endfunction

    function automatic logic [31:0] model_target(input int d, input logic [31:0] pc);
        return model_predict(d, pc) ? m_tgt[d][bidx_of(pc)] : pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[d][i] = 1'b0;
                m_tag[d][i] = 0;
                m_tgt[d][i] = 32'h0;
                m_pht[d][i] = 1;
            end
            m_ghr[d] = 0;
            m_pb[d] = 0;
            m_pm[d] = 0;
        end
    endtask

    task automatic model_update(input int d, input logic tk, input logic [31:0] mpc,
                                input logic [31:0] res, input bit fl);
        int p;
        p = pidx_of(d, mpc, int'(mghr[d]));
        if (tk) m_pht[d][p] = (m_pht[d][p] < 3) ? m_pht[d][p] + 1 : 3;
        else    m_pht[d][p] = (m_pht[d][p] > 0) ? m_pht[d][p] - 1 : 0;
        if (tk) begin
            m_valid[d][bidx_of(mpc)] = 1'b1;
            m_tag[d][bidx_of(mpc)] = tag_of(mpc);
            m_tgt[d][bidx_of(mpc)] = res;
        end
        m_ghr[d] = (m_ghr[d] * 2 + int'(tk)) % 16;
        if (m_pb[d] < pmax[d]) m_pb[d] = m_pb[d] + 1;
        if (fl && (m_pm[d] < pmax[d])) m_pm[d] = m_pm[d] + 1;
    endtask

    // values the pipeline would have carried had mpc just been fetched
    task automatic carry_from_model(input logic [31:0] mpc);
        for (int d = 0; d < 2; d++) begin
            mpred[d] = model_predict(d, mpc);
            mtgt[d]  = model_target(d, mpc);
            mghr[d]  = 4'(m_ghr[d]);
        end
    endtask

    task automatic step(input logic [31:0] pc, input logic br, input logic tk,
                        input logic [31:0] mpc, input logic [31:0] res, input string nm);
        bit e_miss, e_flush;
        logic [31:0] e_tgt;
        bit fl [2];
        fetch_pc = pc; mem_branch = br; mem_taken = tk; mem_pc = mpc; mem_target_res = res;
        #1;
        for (int d = 0; d < 2; d++) begin
            e_miss  = br && (mpred[d] != tk);
            e_flush = br && (e_miss || (tk && mpred[d] && (mtgt[d] != res)));
            e_tgt   = e_flush ? (tk ? res : mpc + 32'd4) : model_target(d, pc);
            fl[d]   = e_flush;
            check($sformatf("%s/d%0d/predict", nm, d), 64'(f_pred_w[d]), 64'(model_predict(d, pc)));
            check($sformatf("%s/d%0d/target", nm, d), 64'(f_tgt_w[d]), 64'(e_tgt));
            check($sformatf("%s/d%0d/ghr", nm, d), 64'(f_ghr_w[d]), 64'(m_ghr[d]));
            check($sformatf("%s/d%0d/flush", nm, d), 64'(flush_w[d]), 64'(e_flush));
            check($sformatf("%s/d%0d/miss", nm, d), 64'(miss_w[d]), 64'(e_miss));
        end
        check({nm, "/d0/perf_b"}, 64'(pb0), 64'(m_pb[0]));
        check({nm, "/d0/perf_m"}, 64'(pm0), 64'(m_pm[0]));
        check({nm, "/d1/perf_b"}, 64'(pb1), 64'(m_pb[1]));
        check({nm, "/d1/perf_m"}, 64'(pm1), 64'(m_pm[1]));
        if (nRST && br) begin
            for (int d = 0; d < 2; d++) model_update(d, tk, mpc, res, fl[d]);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // pulse reset between clock edges; state must clear with no edge
    task automatic async_reset(input string nm);
        mem_branch = 1'b0;
        #2 nRST = 1'b0;
        #1;
        model_reset();
        check({nm, "/predict"}, 64'(f_pred_w[0]), 64'(0));
        check({nm, "/target"}, 64'(f_tgt_w[1]), 64'(fetch_pc + 32'd4));
        check({nm, "/perf"}, 64'(pb0), 64'(0));
        check({nm, "/ghr"}, 64'(f_ghr_w[1]), 64'(0));
        #1 nRST = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        int late_miss0;
        logic [31:0] rpc, rmpc, rres;
        pmax[0] = 15;
        pmax[1] = 64'hFFFF_FFFF;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            mpred[d] = 1'b0; mtgt[d] = 32'h0; mghr[d] = 4'h0;
        end

        // reset state
        step(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, "reset");
        check("reset/target_const", 64'(f_tgt_w[0]), 64'h104);
        tick();
        nRST = 1'b1;
        tick();

        // cold mispredict
        mpred[0] = 1'b0; mpred[1] = 1'b0; mtgt[0] = 32'h204; mtgt[1] = 32'h204;
        mghr[0] = 4'h0; mghr[1] = 4'h0;
        step(32'h100, 1'b1, 1'b1, 32'h200, 32'h240, "cold");
        check("cold/flush_const", 64'(flush_w[0]), 64'(1));
        check("cold/miss_const", 64'(miss_w[0]), 64'(1));
        check("cold/target_const", 64'(f_tgt_w[0]), 64'h240);
        tick();
        step(32'h200, 1'b0, 1'b0, 32'h0, 32'h0, "cold_next");
        check("cold_next/predict_const", 64'(f_pred_w[0]), 64'(1));
        check("cold_next/target_const", 64'(f_tgt_w[0]), 64'h240);
        tick();

        // predicted taken to 0x240, resolved taken to 0x280
        mpred[0] = 1'b1; mpred[1] = 1'b1; mtgt[0] = 32'h240; mtgt[1] = 32'h240;
        mghr[0] = f_ghr_w[0]; mghr[1] = 4'(m_ghr[1]);
        step(32'h100, 1'b1, 1'b1, 32'h200, 32'h280, "tmis");
        check("tmis/flush_const", 64'(flush_w[0]), 64'(1));
        check("tmis/miss_const", 64'(miss_w[0]), 64'(0));
        check("tmis/target_const", 64'(f_tgt_w[0]), 64'h280);
        tick();
        step(32'h200, 1'b0, 1'b0, 32'h0, 32'h0, "tmis_next");
        check("tmis_next/target_const", 64'(f_tgt_w[0]), 64'h280);
        tick();

        // aliasing: same index, different tag
        step(32'h600, 1'b0, 1'b0, 32'h0, 32'h0, "alias");
        check("alias/predict_const", 64'(f_pred_w[0]), 64'(0));
        check("alias/target_const", 64'(f_tgt_w[0]), 64'h604);
        tick();

        // counter at 3: four not-taken updates, then one taken must leave it not-taken
        for (int i = 0; i < 4; i++) begin
            carry_from_model(32'h200);
            step(32'h200, 1'b1, 1'b0, 32'h200, 32'h280, $sformatf("satdn%0d", i));
            tick();
        end
        carry_from_model(32'h200);
        step(32'h200, 1'b1, 1'b1, 32'h200, 32'h280, "satup0");
        tick();
        step(32'h200, 1'b0, 1'b0, 32'h0, 32'h0, "sat_floor");
        check("sat_floor/predict_const", 64'(f_pred_w[0]), 64'(0));
        tick();
        carry_from_model(32'h200);
        step(32'h200, 1'b1, 1'b1, 32'h200, 32'h280, "satup1");
        tick();
        step(32'h200, 1'b0, 1'b0, 32'h0, 32'h0, "sat_rise");
        check("sat_rise/predict_const", 64'(f_pred_w[0]), 64'(1));

        // mid-run async reset clears training
        fetch_pc = 32'h200;
        async_reset("midreset");

        // 20 mispredicted branches: 4-bit counters stop at 15
        for (int i = 0; i < 20; i++) begin
            mpred[0] = 1'b0; mpred[1] = 1'b0; mtgt[0] = 32'h0; mtgt[1] = 32'h0;
            mghr[0] = 4'h0; mghr[1] = 4'h0;
            step(32'h100, 1'b1, 1'b1, 32'h200, 32'h240, $sformatf("perf%0d", i));
            tick();
        end
        step(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, "perf_end");
        check("perf_end/d0_b_const", 64'(pb0), 64'd15);
        check("perf_end/d0_m_const", 64'(pm0), 64'd15);
        check("perf_end/d1_b_const", 64'(pb1), 64'd20);
        check("perf_end/d1_m_const", 64'(pm1), 64'd20);
        tick();

        // randomized mix of lookups and resolves
        for (int i = 0; i < 300; i++) begin
            rpc  = 32'h200 + (32'($urandom_range(0, 3)) << 2) + (32'($urandom_range(0, 1)) << 10);
            rmpc = 32'h200 + (32'($urandom_range(0, 3)) << 2) + (32'($urandom_range(0, 1)) << 10);
            rres = ($urandom_range(0, 1) == 0) ? 32'h240 : 32'h280;
            if ($urandom_range(0, 1) == 0) begin
                carry_from_model(rmpc);
            end else begin
                for (int d = 0; d < 2; d++) begin
                    mpred[d] = 1'($urandom_range(0, 1));
                    mtgt[d]  = ($urandom_range(0, 1) == 0) ? 32'h240 : 32'h280;
                    mghr[d]  = 4'($urandom_range(0, 15));
                end
            end
            step(rpc, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), rmpc, rres,
                 $sformatf("rnd%0d", i));
            tick();
        end

        // alternating branch: gshare learns it, bimodal keeps missing
        fetch_pc = 32'h300;
        async_reset("gsreset");
        late_miss0 = 0;
        for (int i = 0; i < 16; i++) begin
            step(32'h300, 1'b0, 1'b0, 32'h0, 32'h0, $sformatf("gsf%0d", i));
            carry_from_model(32'h300);
            tick();
            step(32'h104, 1'b1, 1'((i % 2) == 0), 32'h300, 32'h340, $sformatf("gsr%0d", i));
            if (i >= 8) begin
                check($sformatf("gsr%0d/gshare_nomiss", i), 64'(miss_w[1]), 64'(0));
                if (miss_w[0]) late_miss0++;
            end
            tick();
        end
        check("gs/bimodal_misses", 64'(late_miss0 != 0), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
